// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS decode constants plus the MULT/DIV unit's op codes and FSM encoding.
package mult_div_unit_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_MFHI   = 6'h10;
  localparam logic [5:0] FUNCT_MFLO   = 6'h12;
  localparam logic [5:0] MULT_FUNCT   = 6'h18;
  localparam logic [5:0] DIV_FUNCT    = 6'h1a;

  localparam logic [3:0] ALU_OP_ADD   = 4'h0;
  localparam logic [3:0] ALU_OP_SUB   = 4'h1;
  localparam logic [1:0] SHIFT_OP_SLL = 2'h0;
  localparam logic [1:0] SHIFT_OP_SRL = 2'h1;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMultRun = 2'd1,
    StDivRun  = 2'd2,
    StFinish  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, try subtract.
module md_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    // Modular subtract is exact whenever the subtract is taken (result < divisor).
    diff    = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next  = diff;
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = shifted[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT (radix-2 Booth) / DIV (restoring) unit with HI/LO result registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  md_state_t        state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] mcand;   // multiplicand, or divisor magnitude
  logic [WIDTH:0]   acc;     // Booth P_hi, or partial remainder in the low WIDTH bits
  logic [WIDTH-1:0] plo;     // Booth P_lo, or dividend/quotient shift register
  logic             qm1;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_sum, booth_acc_n;
  logic [WIDTH-1:0] booth_lo_n;
  logic [WIDTH-1:0] rem_n, quot_n;

  always_comb begin
    a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    unique case ({plo[0], qm1})
      2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
      default: booth_sum = acc;
    endcase
    booth_acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_lo_n  = {booth_sum[0], plo[WIDTH-1:1]};
  end

  md_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (acc[WIDTH-1:0]),
    .quot     (plo),
    .divisor  (mcand),
    .rem_next (rem_n),
    .quot_next(quot_n)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      plo      <= '0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy  <= 1'b1;
            cnt   <= CntW'(WIDTH);
            acc   <= '0;
            qm1   <= 1'b0;
            neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_r <= a_in[WIDTH-1];
            if (op == MD_OP_MULT) begin
              mcand <= a_in;
              plo   <= b_in;
              state <= StMultRun;
            end else if (b_in == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= StFinish;
            end else begin
              mcand <= b_mag;
              plo   <= a_mag;
              state <= StDivRun;
            end
          end
        end
        StMultRun: begin
          acc <= booth_acc_n;
          plo <= booth_lo_n;
          qm1 <= plo[0];
          cnt <= cnt - CntW'(1);
          // Results land on the last step so HI/LO are valid alongside done.
          if (cnt == CntW'(1)) begin
            hi_out <= booth_acc_n[WIDTH-1:0];
            lo_out <= booth_lo_n;
            done   <= 1'b1;
            state  <= StFinish;
          end
        end
        StDivRun: begin
          acc <= {1'b0, rem_n};
          plo <= quot_n;
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            hi_out <= neg_r ? -rem_n : rem_n;
            lo_out <= neg_q ? -quot_n : quot_n;
            done   <= 1'b1;
            state  <= StFinish;
          end
        end
        StFinish: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
